// File: rtl/uart_prog_loader.sv
// Framed UART program loader: parses load packets from a received byte stream, writes
// assembled words into one of NUM_BANKS memories and holds the core in reset until RUN.
module uart_prog_loader #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 14,
  parameter int NUM_BANKS      = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int BANK_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              we_o,
  output logic [BANK_W-1:0] bank_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              core_rst_o,
  output logic              done_o,
  output logic [1:0]        err_o,
  output logic              busy_o
);
  localparam int BPW        = DATA_W / 8;
  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int MAX_AB     = (BPW > ADDR_BYTES) ? BPW : ADDR_BYTES;
  localparam int MAX_BYTES  = (MAX_AB > 2) ? MAX_AB : 2;
  localparam int BCNT_W     = $clog2(MAX_BYTES);
  localparam int TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] RUN_BYTE  = 8'h5A;

  typedef enum logic [2:0] {ST_IDLE, ST_BANK, ST_ADDR, ST_LEN, ST_DATA, ST_CSUM, ST_ERR} state_t;

  state_t              state_reg, state_next;
  logic [BCNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [15:0]         len_reg, len_next;
  logic [7:0]          csum_reg, csum_next;
  logic [TO_W-1:0]     to_cnt_reg, to_cnt_next;
  logic                loaded_reg, loaded_next;
  logic                we_reg, we_next;
  logic [BANK_W-1:0]   bank_reg, bank_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                core_rst_reg, core_rst_next;
  logic                done_reg, done_next;
  logic [1:0]          err_reg, err_next;

  logic [BPW-1:0]      lane_sel;
  logic                to_expire;
  logic [15:0]         len_full;

  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : g_lane
      assign lane_sel[gi] = (byte_cnt_reg == BCNT_W'(gi));
    end
  endgenerate

  // An incoming byte always beats an expiring idle counter.
  assign to_expire = (TIMEOUT_CYCLES > 0) && (state_reg != ST_IDLE) && !rx_dv_i &&
                     (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
  assign len_full  = {len_reg[7:0], rx_byte_i};

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    len_next      = len_reg;
    csum_next     = csum_reg;
    loaded_next   = loaded_reg;
    we_next       = 1'b0;
    bank_next     = bank_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    core_rst_next = core_rst_reg;
    done_next     = 1'b0;
    err_next      = err_reg;

    if (rx_dv_i || state_reg == ST_IDLE || to_expire) to_cnt_next = '0;
    else                                              to_cnt_next = to_cnt_reg + TO_W'(1);

    // Post-increment after the write strobe so we_o sees the address just written.
    if (we_reg) addr_next = addr_reg + ADDR_W'(1);

    if (rx_dv_i) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (rx_byte_i == SYNC_BYTE) begin
            state_next    = ST_BANK;
            core_rst_next = 1'b1;
            err_next      = 2'd0;
            loaded_next   = 1'b0;
            csum_next     = 8'h00;
          end else if (rx_byte_i == RUN_BYTE && loaded_reg && err_reg == 2'd0) begin
            core_rst_next = 1'b0;
          end
        end
        ST_BANK: begin
          if (int'(rx_byte_i) < NUM_BANKS) begin
            bank_next     = BANK_W'(rx_byte_i);
            byte_cnt_next = '0;
            state_next    = ST_ADDR;
          end else begin
            err_next   = 2'd2;
            state_next = ST_ERR;
          end
        end
        ST_ADDR: begin
          addr_next = ADDR_W'({addr_reg, rx_byte_i});
          if (byte_cnt_reg == BCNT_W'(ADDR_BYTES - 1)) begin
            byte_cnt_next = '0;
            state_next    = ST_LEN;
          end else begin
            byte_cnt_next = byte_cnt_reg + BCNT_W'(1);
          end
        end
        ST_LEN: begin
          len_next = len_full;
          if (byte_cnt_reg == BCNT_W'(1)) begin
            byte_cnt_next = '0;
            state_next    = (len_full == 16'd0) ? ST_CSUM : ST_DATA;
          end else begin
            byte_cnt_next = byte_cnt_reg + BCNT_W'(1);
          end
        end
        ST_DATA: begin
          for (int k = 0; k < BPW; k++) begin
            if (lane_sel[k]) wdata_next[8*k +: 8] = rx_byte_i;
          end
          csum_next = csum_reg ^ rx_byte_i;
          if (byte_cnt_reg == BCNT_W'(BPW - 1)) begin
            we_next       = 1'b1;
            byte_cnt_next = '0;
            len_next      = len_reg - 16'd1;
            if (len_reg == 16'd1) state_next = ST_CSUM;
          end else begin
            byte_cnt_next = byte_cnt_reg + BCNT_W'(1);
          end
        end
        ST_CSUM: begin
          if (rx_byte_i == csum_reg) begin
            done_next   = 1'b1;
            loaded_next = 1'b1;
          end else begin
            err_next    = 2'd1;
            loaded_next = 1'b0;
          end
          state_next = ST_IDLE;
        end
        default: ;
      endcase
    end else if (to_expire) begin
      state_next    = ST_IDLE;
      byte_cnt_next = '0;
      if (state_reg != ST_ERR) err_next = 2'd3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= ST_IDLE;
      byte_cnt_reg <= '0;
      len_reg      <= 16'd0;
      csum_reg     <= 8'h00;
      to_cnt_reg   <= '0;
      loaded_reg   <= 1'b0;
      we_reg       <= 1'b0;
      bank_reg     <= '0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      core_rst_reg <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 2'd0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      len_reg      <= len_next;
      csum_reg     <= csum_next;
      to_cnt_reg   <= to_cnt_next;
      loaded_reg   <= loaded_next;
      we_reg       <= we_next;
      bank_reg     <= bank_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      core_rst_reg <= core_rst_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign we_o       = we_reg;
  assign bank_o     = bank_reg;
  assign addr_o     = addr_reg;
  assign wdata_o    = wdata_reg;
  assign core_rst_o = core_rst_reg;
  assign done_o     = done_reg;
  assign err_o      = err_reg;
  assign busy_o     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: a table of load frames with hand-computed writes,
// plus hand-written sequences for bad bank, timeouts and reset in mid-frame.
module tb_uart_prog_loader;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 14;
  localparam int NUM_BANKS = 2;
  localparam int TO = 40;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_dv_i = 1'b0;
  logic [7:0]  rx_byte_i = 8'h00;
  logic        we_o, core_rst_o, done_o, busy_o;
  logic [0:0]  bank_o;
  logic [13:0] addr_o;
  logic [31:0] wdata_o;
  logic [1:0]  err_o;

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  uart_prog_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BANKS(NUM_BANKS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_dv_i(rx_dv_i), .rx_byte_i(rx_byte_i),
    .we_o(we_o), .bank_o(bank_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .core_rst_o(core_rst_o), .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
  );

  // Write log: {byte strobe seen one cycle earlier, bank, addr, data}
  logic [47:0] wr_log [64];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic        prev_dv = 1'b0;

  always @(negedge clk_i) begin
    if (we_o) begin
      if (wr_cnt < 64) wr_log[wr_cnt] <= {prev_dv, bank_o, addr_o, wdata_o};
      wr_cnt <= wr_cnt + 1;
    end
    if (done_o) done_cnt <= done_cnt + 1;
    prev_dv <= rx_dv_i;
  end

  typedef struct packed {
    logic [127:0] bytes;   // first byte in the top 8 bits
    logic [7:0]   nbytes;
    logic [7:0]   nwr;
    logic [0:0]   bank;
    logic [13:0]  a0;
    logic [31:0]  d0;
    logic [13:0]  a1;
    logic [31:0]  d1;
    logic [7:0]   ndone;
    logic [1:0]   err;
    logic         run_rst;  // core_rst_o expected after a following RUN byte
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv_i   = 1'b1;
    rx_byte_i = b;
    @(posedge clk_i);
    #1;
    rx_dv_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " we"}, 32'(we_o), 32'd0);
    check({tag, " bank"}, 32'(bank_o), 32'd0);
    check({tag, " addr"}, 32'(addr_o), 32'd0);
    check({tag, " wdata"}, wdata_o, 32'd0);
    check({tag, " core_rst"}, 32'(core_rst_o), 32'd1);
    check({tag, " done"}, 32'(done_o), 32'd0);
    check({tag, " err"}, 32'(err_o), 32'd0);
    check({tag, " busy"}, 32'(busy_o), 32'd0);
  endtask

  task automatic run_frame(input int idx);
    vec_t v;
    int wbase, dbase;
    logic [7:0] b;
    logic [47:0] e;
    v = vecs[idx];
    wbase = wr_cnt;
    dbase = done_cnt;
    for (int i = 0; i < int'(v.nbytes); i++) begin
      b = v.bytes[127 - 8*i -: 8];
      send_byte(b);
    end
    idle(3);
    check($sformatf("v%0d nwr", idx), 32'(wr_cnt - wbase), 32'(v.nwr));
    for (int j = 0; j < int'(v.nwr) && j < 2 && (wbase + j) < 64; j++) begin
      e = wr_log[wbase + j];
      check($sformatf("v%0d w%0d latency", idx, j), 32'(e[47]), 32'd1);
      check($sformatf("v%0d w%0d bank", idx, j), 32'(e[46]), 32'(v.bank));
      check($sformatf("v%0d w%0d addr", idx, j), 32'(e[45:32]), 32'((j == 0) ? v.a0 : v.a1));
      check($sformatf("v%0d w%0d data", idx, j), e[31:0], (j == 0) ? v.d0 : v.d1);
    end
    check($sformatf("v%0d done", idx), 32'(done_cnt - dbase), 32'(v.ndone));
    check($sformatf("v%0d err", idx), 32'(err_o), 32'(v.err));
    check($sformatf("v%0d busy", idx), 32'(busy_o), 32'd0);
    check($sformatf("v%0d core_rst held", idx), 32'(core_rst_o), 32'd1);
    send_byte(8'h5A);
    idle(2);
    check($sformatf("v%0d core_rst after RUN", idx), 32'(core_rst_o), 32'(v.run_rst));
    $display("frame %0d: bytes=%0d writes=%0d done=%0d err=%0d core_rst=%0b",
             idx, v.nbytes, wr_cnt - wbase, done_cnt - dbase, err_o, core_rst_o);
  endtask

  initial begin
    int wbase, dbase;

    vecs[0] = '{bytes: 128'hA501_0010_0002_1122_3344_5566_7788_8800, nbytes: 8'd15, nwr: 8'd2,
                bank: 1'b1, a0: 14'h0010, d0: 32'h44332211, a1: 14'h0011, d1: 32'h88776655,
                ndone: 8'd1, err: 2'd0, run_rst: 1'b0};
    vecs[1] = '{bytes: 128'hA501_0010_0002_1122_3344_5566_7788_0000, nbytes: 8'd15, nwr: 8'd2,
                bank: 1'b1, a0: 14'h0010, d0: 32'h44332211, a1: 14'h0011, d1: 32'h88776655,
                ndone: 8'd0, err: 2'd1, run_rst: 1'b1};
    vecs[2] = '{bytes: 128'hA500_3FFF_0002_0102_0304_0506_0708_0800, nbytes: 8'd15, nwr: 8'd2,
                bank: 1'b0, a0: 14'h3FFF, d0: 32'h04030201, a1: 14'h0000, d1: 32'h08070605,
                ndone: 8'd1, err: 2'd0, run_rst: 1'b0};
    vecs[3] = '{bytes: 128'hA500_0000_0000_0000_0000_0000_0000_0000, nbytes: 8'd7, nwr: 8'd0,
                bank: 1'b0, a0: 14'h0, d0: 32'h0, a1: 14'h0, d1: 32'h0,
                ndone: 8'd1, err: 2'd0, run_rst: 1'b0};
    vecs[4] = '{bytes: 128'hA501_FF20_0001_DEAD_BEEF_2200_0000_0000, nbytes: 8'd11, nwr: 8'd1,
                bank: 1'b1, a0: 14'h3F20, d0: 32'hEFBEADDE, a1: 14'h0, d1: 32'h0,
                ndone: 8'd1, err: 2'd0, run_rst: 1'b0};
    vecs[5] = '{bytes: 128'hA500_0005_0001_A55A_A55A_0000_0000_0000, nbytes: 8'd11, nwr: 8'd1,
                bank: 1'b0, a0: 14'h0005, d0: 32'h5AA55AA5, a1: 14'h0, d1: 32'h0,
                ndone: 8'd1, err: 2'd0, run_rst: 1'b0};
    vecs[6] = '{bytes: 128'hA501_0030_0001_DEAD_BEEF_2200_0000_0000, nbytes: 8'd11, nwr: 8'd1,
                bank: 1'b1, a0: 14'h0030, d0: 32'hEFBEADDE, a1: 14'h0, d1: 32'h0,
                ndone: 8'd1, err: 2'd0, run_rst: 1'b0};

    idle(3);
    rst_i = 1'b0;
    idle(1);
    check_reset_values("reset");

    for (int n = 0; n < 6; n++) run_frame(n);

    // Plain reset must also forget a good load: RUN afterwards is ignored.
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    check("rst core_rst", 32'(core_rst_o), 32'd1);
    send_byte(8'h5A);
    idle(2);
    check("rst then RUN core_rst", 32'(core_rst_o), 32'd1);
    $display("reset then RUN: core_rst=%0b", core_rst_o);

    // Reset together with a byte strobe, right after the LEN bytes.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h30);
    send_byte(8'h00); send_byte(8'h01);
    rst_i = 1'b1; rx_dv_i = 1'b1; rx_byte_i = 8'h77;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; rx_dv_i = 1'b0;
    check_reset_values("midframe rst");
    $display("reset mid-frame: busy=%0b err=%0d", busy_o, err_o);
    run_frame(6);

    // Bad bank: following bytes ignored until the idle timeout.
    wbase = wr_cnt;
    send_byte(8'hA5); send_byte(8'h03);
    for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i));
    idle(2);
    check("badbank err", 32'(err_o), 32'd2);
    check("badbank busy", 32'(busy_o), 32'd1);
    check("badbank no write", 32'(wr_cnt - wbase), 32'd0);
    idle(TO - 8);
    check("badbank busy before timeout", 32'(busy_o), 32'd1);
    idle(10);
    check("badbank busy after timeout", 32'(busy_o), 32'd0);
    check("badbank err after timeout", 32'(err_o), 32'd2);
    send_byte(8'hA5);
    idle(1);
    check("badbank new sync clears err", 32'(err_o), 32'd0);
    dbase = done_cnt;
    for (int i = 0; i < 6; i++) send_byte(8'h00);
    idle(2);
    check("badbank recovery done", 32'(done_cnt - dbase), 32'd1);
    $display("bad bank: err cleared to %0d, done=%0d", err_o, done_cnt - dbase);

    // Timeout after two payload bytes: no partial write, err 3.
    wbase = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
    idle(TO + 4);
    check("timeout err", 32'(err_o), 32'd3);
    check("timeout busy", 32'(busy_o), 32'd0);
    check("timeout no write", 32'(wr_cnt - wbase), 32'd0);
    $display("timeout mid-payload: err=%0d busy=%0b", err_o, busy_o);

    // A byte landing on the very cycle the idle limit is reached keeps the frame alive.
    dbase = done_cnt;
    send_byte(8'hA5);
    repeat (TO - 1) @(posedge clk_i);
    #1;
    for (int i = 0; i < 6; i++) send_byte(8'h00);
    idle(2);
    check("expiry race err", 32'(err_o), 32'd0);
    check("expiry race done", 32'(done_cnt - dbase), 32'd1);
    $display("expiry race: err=%0d done=%0d", err_o, done_cnt - dbase);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
